// File: rtl/rx_frame_assembler.sv
// Serial receive front end: synchronises rx_serial, frames start/data/stop bits and
// assembles one FRAME_BITS-wide word (MSB first) with valid/ack handshake and error pulses.
module rx_frame_assembler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_BITS   = 55
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_serial,
    input  logic                  frame_ack,
    output logic [FRAME_BITS-1:0] RX_Data,
    output logic                  frame_vld,
    output logic                  framing_err,
    output logic                  overrun_err,
    output logic                  busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_rxs;
    logic [BW-1:0]         r_baud_cnt;
    logic [BW-1:0]         w_baud_nxt;
    logic [CW-1:0]         r_bit_cnt;
    logic [CW-1:0]         w_bit_nxt;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [FRAME_BITS-1:0] w_shreg_nxt;
    logic [FRAME_BITS-1:0] r_data;
    logic                  r_vld;
    logic                  r_ferr;
    logic                  r_ovr;
    logic                  w_load;
    logic                  w_ferr;

    // Line is idle-high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_rxs   <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + 1'b1;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (!r_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_baud_cnt == BW'(CLKS_PER_BIT / 2 - 1)) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
                    w_baud_nxt  = '0;
                    w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], r_rxs};
                    if (r_bit_cnt == CW'(FRAME_BITS - 1)) w_state_nxt = S_STOP;
                    else                                  w_bit_nxt   = r_bit_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
                    w_baud_nxt = '0;
                    if (r_rxs) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                w_baud_nxt = '0;
                if (r_rxs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A load wins over a same-cycle ack; overrun only when the old frame was never taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= w_load & r_vld & ~frame_ack;
            if (w_load) begin
                r_data <= r_shreg;
                r_vld  <= 1'b1;
            end else if (frame_ack) begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign RX_Data     = r_data;
    assign frame_vld   = r_vld;
    assign framing_err = r_ferr;
    assign overrun_err = r_ovr;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler: table of single frames plus hand sequences for
// glitch, WAIT_HI, overrun, ack-on-load and mid-frame reset.
module tb_rx_frame_assembler;
    localparam int CPB = 16;
    localparam int FB  = 55;
    localparam logic [54:0] F    = {3'b101, 4'hC, 48'h0123_4567_89AB};
    localparam logic [54:0] ONES = 55'h7F_FFFF_FFFF_FFFF;
    localparam logic [54:0] ALT  = 55'h2A_AAAA_AAAA_AAAA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_serial = 1'b1;
    logic        frame_ack = 1'b0;
    logic [54:0] RX_Data;
    logic        frame_vld;
    logic        framing_err;
    logic        overrun_err;
    logic        busy;

    rx_frame_assembler #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_serial  (rx_serial),
        .frame_ack  (frame_ack),
        .RX_Data    (RX_Data),
        .frame_vld  (frame_vld),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned t_start = 0;
    int unsigned rise_cyc = 0;
    int          n_ferr = 0;
    int          n_ovr = 0;
    logic        busy_seen = 1'b0;
    logic        prev_vld = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_vld && !prev_vld) rise_cyc = cyc;
        prev_vld = frame_vld;
        if (framing_err) n_ferr++;
        if (overrun_err) n_ovr++;
        if (busy) busy_seen = 1'b1;
        if (framing_err && overrun_err) begin
            bad++;
            $display("FAIL err_exclusive: got both pulses expected at most one");
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        tick(CPB);
    endtask

    // Leaves the line at the stop level; ack_load pulses frame_ack on the load edge.
    task automatic send_frame(input logic [54:0] d, input logic stop, input logic ack_load);
        t_start = cyc + 1;
        drive_bit(1'b0);
        for (int i = FB - 1; i >= 0; i--) drive_bit(d[i]);
        if (ack_load) begin
            rx_serial = stop;
            tick(10);
            frame_ack = 1'b1;
            tick(1);
            frame_ack = 1'b0;
            tick(CPB - 11);
        end else begin
            drive_bit(stop);
        end
    endtask

    task automatic do_ack(input string name);
        chk({name, "_vld_before_ack"}, 64'(frame_vld), 64'd1);
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
        chk({name, "_vld_after_ack"}, 64'(frame_vld), 64'd0);
    endtask

    typedef struct {
        logic [54:0] data;
        logic        stop;
        logic [54:0] exp_data;
        logic        exp_vld;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ferr0;
        int ovr0;
        logic [54:0] old;

        vecs[0] = '{F,      1'b1, F,      1'b1, 0};
        vecs[1] = '{55'h0,  1'b1, 55'h0,  1'b1, 0};
        vecs[2] = '{ALT,    1'b1, ALT,    1'b1, 0};
        vecs[3] = '{F,      1'b0, ALT,    1'b0, 1};
        vecs[4] = '{ONES,   1'b1, ONES,   1'b1, 0};
        vecs[5] = '{55'h1,  1'b1, 55'h1,  1'b1, 0};

        tick(3);
        chk("rst_data", 64'(RX_Data), 64'd0);
        chk("rst_vld",  64'(frame_vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_errs", 64'({framing_err, overrun_err}), 64'd0);
        rst_n = 1'b1;
        tick(3);

        for (int v = 0; v < 6; v++) begin
            ferr0 = n_ferr;
            ovr0  = n_ovr;
            send_frame(vecs[v].data, vecs[v].stop, 1'b0);
            rx_serial = 1'b1;
            tick(4);
            chk($sformatf("v%0d_data", v), 64'(RX_Data), 64'(vecs[v].exp_data));
            chk($sformatf("v%0d_vld", v), 64'(frame_vld), 64'(vecs[v].exp_vld));
            chk($sformatf("v%0d_ferr", v), 64'(n_ferr - ferr0), 64'(vecs[v].exp_ferr));
            chk($sformatf("v%0d_ovr", v), 64'(n_ovr - ovr0), 64'd0);
            chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
            if (vecs[v].exp_vld) begin
                chk($sformatf("v%0d_latency", v), 64'(rise_cyc - t_start), 64'd906);
                do_ack($sformatf("v%0d", v));
            end
        end

        // Short low glitch must be rejected at the mid-start resample.
        old = RX_Data;
        ferr0 = n_ferr;
        busy_seen = 1'b0;
        rx_serial = 1'b0;
        tick(5);
        rx_serial = 1'b1;
        tick(20);
        chk("glitch_busy_seen", 64'(busy_seen), 64'd1);
        chk("glitch_busy_end", 64'(busy), 64'd0);
        chk("glitch_vld", 64'(frame_vld), 64'd0);
        chk("glitch_ferr", 64'(n_ferr - ferr0), 64'd0);
        chk("glitch_data", 64'(RX_Data), 64'(old));

        // Bad stop with the line held low: WAIT_HI must not treat it as a new start.
        ferr0 = n_ferr;
        send_frame(ONES, 1'b0, 1'b0);
        tick(48);
        chk("waithi_ferr", 64'(n_ferr - ferr0), 64'd1);
        chk("waithi_busy_low_line", 64'(busy), 64'd1);
        rx_serial = 1'b1;
        tick(4);
        chk("waithi_busy_released", 64'(busy), 64'd0);
        chk("waithi_vld", 64'(frame_vld), 64'd0);
        chk("waithi_data", 64'(RX_Data), 64'(old));

        // Back-to-back frames with no ack.
        ovr0 = n_ovr;
        send_frame(F, 1'b1, 1'b0);
        send_frame(55'h0, 1'b1, 1'b0);
        rx_serial = 1'b1;
        tick(4);
        chk("ovr_count", 64'(n_ovr - ovr0), 64'd1);
        chk("ovr_data", 64'(RX_Data), 64'd0);
        chk("ovr_vld", 64'(frame_vld), 64'd1);

        // Ack lands on the same edge the next frame loads.
        ovr0 = n_ovr;
        send_frame(ONES, 1'b1, 1'b1);
        rx_serial = 1'b1;
        tick(4);
        chk("ackload_vld", 64'(frame_vld), 64'd1);
        chk("ackload_ovr", 64'(n_ovr - ovr0), 64'd0);
        chk("ackload_data", 64'(RX_Data), 64'(ONES));

        // Reset in the middle of data bit 30, then a clean frame.
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = FB - 1; i > FB - 31; i--) drive_bit(F[i]);
        rx_serial = F[FB-31];
        tick(8);
        chk("prerst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 64'(RX_Data), 64'd0);
        chk("midrst_vld", 64'(frame_vld), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_errs", 64'({framing_err, overrun_err}), 64'd0);
        rx_serial = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        ferr0 = n_ferr;
        ovr0  = n_ovr;
        send_frame(F, 1'b1, 1'b0);
        rx_serial = 1'b1;
        tick(4);
        chk("postrst_data", 64'(RX_Data), 64'(F));
        chk("postrst_vld", 64'(frame_vld), 64'd1);
        chk("postrst_errs", 64'((n_ferr - ferr0) + (n_ovr - ovr0)), 64'd0);
        do_ack("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
